gshare_predictor: RTL

// - Clocked, parametrised global-history branch predictor: a table of 2^IDX_W saturating

---
 rtl/bp_pkg.sv | 25 ++
 rtl/bp_counter_table.sv | 31 +++
 rtl/gshare_predictor.sv | 108 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the FSM state encoding and the saturating counter step.
package bp_pkg;

    localparam int MISS_W = 16;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    function automatic int unsigned sat_next(
        input int unsigned ctr,
        input logic        taken,
        input int          ctr_w
    );
        int unsigned top;
        top = (32'd1 << ctr_w) - 32'd1;
        if (taken)
            sat_next = (ctr >= top) ? top : ctr + 32'd1;
        else
            sat_next = (ctr == 32'd0) ? 32'd0 : ctr - 32'd1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Saturating counter storage: async read, update port and init sweep port.
// The sweep write wins when both ports are active in one cycle.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             sweep_en,
    input  logic [IDX_W-1:0] sweep_idx,
    input  logic [CTR_W-1:0] sweep_val
);

    logic [CTR_W-1:0] mem [2**IDX_W];

    assign rd_ctr = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (sweep_en)
            mem[sweep_idx] <= sweep_val;
        else if (upd_en)
            mem[upd_idx] <= CTR_W'(sat_next(32'(mem[upd_idx]), upd_taken, CTR_W));
    end

endmodule

// File: rtl/gshare_predictor.sv
// Global-history branch predictor: FSM, history, index logic and statistics.
// Predictions read the table before any same-cycle update lands.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W    = 6,
    parameter int HIST_W   = 4,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter bit USE_PC   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [IDX_W-1:0]  pred_pc,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [IDX_W-1:0]  pred_idx,
    input  logic              upd_valid,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_taken,
    input  logic              upd_pred,
    output logic [HIST_W-1:0] ghist,
    output logic [MISS_W-1:0] miss_count
);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] sweep_ptr;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] rd_ctr;
    logic             pred_fire;
    logic             upd_fire;
    logic             sweep_en;
    logic             sweep_last;

    assign idx = USE_PC ? (pred_pc ^ IDX_W'(ghist)) : IDX_W'(ghist);
    assign sweep_last = &sweep_ptr;
    // flush wins over any request arriving in the same cycle
    assign pred_fire = ready & pred_valid & ~flush;
    assign upd_fire = ready & upd_valid & ~flush;
    assign sweep_en = (state == ST_INIT) & rst_n & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush)
            state_nxt = ST_INIT;
        else if (state == ST_INIT && sweep_last)
            state_nxt = ST_RUN;
    end

    always_comb begin
        ready = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sweep_ptr      <= '0;
            ghist          <= '0;
            pred_out_valid <= 1'b0;
            pred_taken     <= 1'b0;
            pred_idx       <= '0;
            miss_count     <= '0;
        end else if (flush) begin
            sweep_ptr      <= '0;
            ghist          <= '0;
            pred_out_valid <= 1'b0;
        end else begin
            pred_out_valid <= pred_fire;
            if (pred_fire) begin
                pred_taken <= rd_ctr[CTR_W-1];
                pred_idx   <= idx;
            end
            if (sweep_en)
                sweep_ptr <= sweep_ptr + 1'b1;
            if (upd_fire) begin
                ghist <= (ghist << 1) | HIST_W'(upd_taken);
                if (upd_pred != upd_taken && miss_count != '1)
                    miss_count <= miss_count + 1'b1;
            end
        end
    end

    bp_counter_table #(
        .IDX_W(IDX_W),
        .CTR_W(CTR_W)
    ) u_table (
        .clk      (clk),
        .rd_idx   (idx),
        .rd_ctr   (rd_ctr),
        .upd_en   (upd_fire),
        .upd_idx  (upd_idx),
        .upd_taken(upd_taken),
        .sweep_en (sweep_en),
        .sweep_idx(sweep_ptr),
        .sweep_val(CTR_W'(CTR_INIT))
    );

endmodule
